// File: rtl/fetch_queue_if.sv
// Fetch queue bus: instruction-memory request/response, redirect and decode handshake.
// master = fetch_queue side, slave = core/memory side.
interface fetch_queue_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              redirect_i;
    logic [AWIDTH-1:0] redirect_pc_i;
    logic              imem_req_o;
    logic [AWIDTH-1:0] imem_addr_o;
    logic              imem_rvalid_i;
    logic [DWIDTH-1:0] imem_rdata_i;
    logic              dec_valid_o;
    logic [AWIDTH-1:0] dec_pc_o;
    logic [DWIDTH-1:0] dec_insn_o;
    logic              dec_ready_i;
    logic [CW-1:0]     count_o;
    logic              err_o;

    modport master (
        input  redirect_i, redirect_pc_i, imem_rvalid_i, imem_rdata_i, dec_ready_i,
        output imem_req_o, imem_addr_o, dec_valid_o, dec_pc_o, dec_insn_o, count_o, err_o
    );

    modport slave (
        output redirect_i, redirect_pc_i, imem_rvalid_i, imem_rdata_i, dec_ready_i,
        input  imem_req_o, imem_addr_o, dec_valid_o, dec_pc_o, dec_insn_o, count_o, err_o
    );
endinterface

// File: rtl/fetch_queue.sv
// Decoupled instruction fetch: sequential PC generation, credit-limited memory requests,
// {pc,insn} FIFO towards decode, and redirect flush that drops stale in-flight responses.
module fetch_queue #(
    parameter int                AWIDTH   = 32,
    parameter int                DWIDTH   = 32,
    parameter logic [AWIDTH-1:0] BASEADDR = 32'h01000000,
    parameter int                DEPTH    = 4
) (
    input logic          clk,
    input logic          rst,
    fetch_queue_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(DEPTH);

    logic [AWIDTH-1:0] r_fetch_pc;
    logic [AWIDTH-1:0] r_resp_pc;
    logic [AWIDTH-1:0] r_pc_mem   [DEPTH];
    logic [DWIDTH-1:0] r_insn_mem [DEPTH];
    logic [PW-1:0]     r_rd_ptr;
    logic [PW-1:0]     r_wr_ptr;
    logic [CW-1:0]     r_count;
    logic [CW-1:0]     r_outstanding;
    logic [CW-1:0]     r_discard;
    logic              r_err;

    logic [CW:0]       w_credit;
    logic              w_issue;
    logic              w_rsp;
    logic              w_drop;
    logic              w_push;
    logic              w_pop;
    logic [CW-1:0]     w_out_next;
    logic [AWIDTH-1:0] w_redir_pc;

    // Outstanding requests reserve FIFO slots, so a push can never find the FIFO full.
    assign w_credit   = {1'b0, r_count} + {1'b0, r_outstanding};
    assign w_issue    = !rst && !bus.redirect_i && (w_credit < (CW+1)'(DEPTH));
    assign w_rsp      = bus.imem_rvalid_i && (r_outstanding != '0);
    assign w_drop     = w_rsp && ((r_discard != '0) || bus.redirect_i);
    assign w_push     = w_rsp && !w_drop;
    assign w_pop      = (r_count != '0) && bus.dec_ready_i && !bus.redirect_i;
    assign w_out_next = r_outstanding + CW'(w_issue) - CW'(w_rsp);
    assign w_redir_pc = bus.redirect_pc_i & ~AWIDTH'(3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc    <= BASEADDR;
            r_resp_pc     <= BASEADDR;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_err         <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc_mem[i]   <= '0;
                r_insn_mem[i] <= '0;
            end
        end else begin
            r_outstanding <= w_out_next;
            if (bus.imem_rvalid_i && (r_outstanding == '0))
                r_err <= 1'b1;

            if (bus.redirect_i) begin
                // Everything still in flight after this cycle's response is stale.
                r_fetch_pc <= w_redir_pc;
                r_resp_pc  <= w_redir_pc;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_count    <= '0;
                r_discard  <= w_out_next;
            end else begin
                if (w_issue)
                    r_fetch_pc <= r_fetch_pc + AWIDTH'(4);
                if (w_rsp && (r_discard != '0))
                    r_discard <= r_discard - CW'(1);
                if (w_push) begin
                    r_pc_mem[r_wr_ptr]   <= r_resp_pc;
                    r_insn_mem[r_wr_ptr] <= bus.imem_rdata_i;
                    r_wr_ptr             <= r_wr_ptr + PW'(1);
                    r_resp_pc            <= r_resp_pc + AWIDTH'(4);
                end
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign bus.imem_req_o  = w_issue;
    assign bus.imem_addr_o = r_fetch_pc;
    assign bus.dec_valid_o = (r_count != '0);
    assign bus.dec_pc_o    = r_pc_mem[r_rd_ptr];
    assign bus.dec_insn_o  = r_insn_mem[r_rd_ptr];
    assign bus.count_o     = r_count;
    assign bus.err_o       = r_err;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: in-order memory model with programmable latency,
// decode-side pop monitor, and hand-computed checks at fixed cycles.
module tb_fetch_queue;
    localparam logic [31:0] BASE = 32'h01000000;
    localparam logic [31:0] KEY  = 32'h5A5A0000;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_queue_if bus ();
    fetch_queue dut (.clk(clk), .rst(rst), .bus(bus));

    int          n_chk   = 0;
    int          n_pass  = 0;
    int          cyc     = 0;
    int          lat     = 1;
    bit          inject  = 0;
    bit          mon_en  = 0;
    logic [31:0] exp_pc  = BASE;
    int          n_pop   = 0;
    int          max_cnt = 0;
    int          n0      = 0;
    req_t        q[$];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Instruction memory: responses in request order, no earlier than lat cycles after issue.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            bus.imem_rvalid_i = 1'b0;
            bus.imem_rdata_i  = '0;
        end else begin
            bus.imem_rvalid_i = 1'b0;
            bus.imem_rdata_i  = '0;
            if (inject) begin
                bus.imem_rvalid_i = 1'b1;
                bus.imem_rdata_i  = 32'hBAD0BAD0;
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                bus.imem_rvalid_i = 1'b1;
                bus.imem_rdata_i  = q[0].addr ^ KEY;
                void'(q.pop_front());
            end
            if (bus.imem_req_o)
                q.push_back('{bus.imem_addr_o, cyc + lat});
        end
    end

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (int'(bus.count_o) > max_cnt) max_cnt = int'(bus.count_o);
            if (bus.dec_valid_o && bus.dec_ready_i && !bus.redirect_i) begin
                check_val("pop_pc", bus.dec_pc_o, exp_pc);
                check_val("pop_insn", bus.dec_insn_o, exp_pc ^ KEY);
                exp_pc = exp_pc + 32'd4;
                n_pop++;
            end
        end
    end

    initial begin
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = '0;
        bus.dec_ready_i   = 1'b0;

        repeat (3) step();
        #1;
        check_val("rst_req", 32'(bus.imem_req_o), 32'd0);
        check_val("rst_addr", bus.imem_addr_o, BASE);
        check_val("rst_valid", 32'(bus.dec_valid_o), 32'd0);
        check_val("rst_count", 32'(bus.count_o), 32'd0);
        check_val("rst_err", 32'(bus.err_o), 32'd0);
        check_val("rst_pc", bus.dec_pc_o, 32'd0);
        check_val("rst_insn", bus.dec_insn_o, 32'd0);

        // streaming after reset, 1-cycle memory
        step(); rst = 1'b0; bus.dec_ready_i = 1'b1; exp_pc = BASE; n_pop = 0; max_cnt = 0; mon_en = 1; #1;
        check_val("t1_c0_req", 32'(bus.imem_req_o), 32'd1);
        check_val("t1_c0_addr", bus.imem_addr_o, BASE);
        check_val("t1_c0_valid", 32'(bus.dec_valid_o), 32'd0);
        step(); #1;
        check_val("t1_c1_valid", 32'(bus.dec_valid_o), 32'd0);
        check_val("t1_c1_addr", bus.imem_addr_o, 32'h01000004);
        step(); #1;
        check_val("t1_c2_valid", 32'(bus.dec_valid_o), 32'd1);
        check_val("t1_c2_pc", bus.dec_pc_o, BASE);
        check_val("t1_c2_count", 32'(bus.count_o), 32'd1);
        repeat (10) step();
        #1;
        check_val("t1_pops", 32'(n_pop), 32'd10);
        check_val("t1_c12_pc", bus.dec_pc_o, 32'h01000028);
        check_val("t1_maxcnt_le2", 32'(max_cnt <= 2), 32'd1);

        // decode stall fills FIFO, then drains in order without gaps
        step(); bus.dec_ready_i = 1'b0;
        repeat (20) step();
        #1;
        check_val("t2_count", 32'(bus.count_o), 32'd4);
        check_val("t2_req", 32'(bus.imem_req_o), 32'd0);
        check_val("t2_valid", 32'(bus.dec_valid_o), 32'd1);
        check_val("t2_head", bus.dec_pc_o, 32'h0100002C);
        step(); bus.dec_ready_i = 1'b1; n0 = n_pop;
        repeat (8) step();
        #1;
        check_val("t2_drain_pops", 32'(n_pop - n0), 32'd8);

        // 3-cycle memory, redirect with 3 requests in flight
        step(); lat = 3; bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h01000200; exp_pc = 32'h01000200; #1;
        check_val("t3_n_req", 32'(bus.imem_req_o), 32'd0);
        step(); bus.redirect_i = 1'b0; #1;
        check_val("t3_n1_req", 32'(bus.imem_req_o), 32'd1);
        check_val("t3_n1_addr", bus.imem_addr_o, 32'h01000200);
        repeat (2) step();
        step(); bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h01000100; exp_pc = 32'h01000100; #1;
        check_val("t3_n4_req", 32'(bus.imem_req_o), 32'd0);
        step(); bus.redirect_i = 1'b0; #1;
        check_val("t3_n5_req", 32'(bus.imem_req_o), 32'd1);
        check_val("t3_n5_addr", bus.imem_addr_o, 32'h01000100);
        check_val("t3_n5_count", 32'(bus.count_o), 32'd0);
        repeat (3) step();
        #1;
        check_val("t3_n8_count", 32'(bus.count_o), 32'd0);
        check_val("t3_n8_valid", 32'(bus.dec_valid_o), 32'd0);
        step(); #1;
        check_val("t3_n9_valid", 32'(bus.dec_valid_o), 32'd1);
        check_val("t3_n9_pc", bus.dec_pc_o, 32'h01000100);
        check_val("t3_n9_insn", bus.dec_insn_o, 32'h01000100 ^ KEY);

        // quiesce, then redirect colliding with a response and a decode handshake
        step(); bus.dec_ready_i = 1'b0; lat = 1;
        repeat (12) step();
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h01000300; exp_pc = 32'h01000300; bus.dec_ready_i = 1'b1;
        step(); bus.redirect_i = 1'b0;
        repeat (8) step();
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h01000400; exp_pc = 32'h01000400; n0 = n_pop; #1;
        check_val("t4_m_valid", 32'(bus.dec_valid_o), 32'd1);
        step(); bus.redirect_i = 1'b0; #1;
        check_val("t4_m1_valid", 32'(bus.dec_valid_o), 32'd0);
        check_val("t4_m1_count", 32'(bus.count_o), 32'd0);
        check_val("t4_no_pop", 32'(n_pop - n0), 32'd0);
        step(); #1;
        check_val("t4_m2_count", 32'(bus.count_o), 32'd0);
        step(); #1;
        check_val("t4_m3_pc", bus.dec_pc_o, 32'h01000400);

        // PC wrap and low-bit masking of the redirect target
        step(); bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'hFFFFFFFC; exp_pc = 32'hFFFFFFFC;
        step(); bus.redirect_i = 1'b0;
        step();
        step(); #1;
        check_val("t5_pc0", bus.dec_pc_o, 32'hFFFFFFFC);
        step(); #1;
        check_val("t5_pc1", bus.dec_pc_o, 32'h00000000);
        step(); #1;
        check_val("t5_pc2", bus.dec_pc_o, 32'h00000004);
        step(); bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h01000102; exp_pc = 32'h01000100;
        step(); bus.redirect_i = 1'b0; #1;
        check_val("t5_mask_addr", bus.imem_addr_o, 32'h01000100);
        check_val("t5_mask_req", 32'(bus.imem_req_o), 32'd1);
        step(); step(); #1;
        check_val("t5_mask_pc", bus.dec_pc_o, 32'h01000100);

        // spurious response sets sticky error, FIFO untouched
        step(); bus.dec_ready_i = 1'b0;
        repeat (10) step();
        #1;
        check_val("t6_full", 32'(bus.count_o), 32'd4);
        check_val("t6_err0", 32'(bus.err_o), 32'd0);
        check_val("t6_head0", bus.dec_pc_o, exp_pc);
        step(); inject = 1'b1;
        step(); inject = 1'b0; #1;
        check_val("t6_err1", 32'(bus.err_o), 32'd1);
        check_val("t6_count", 32'(bus.count_o), 32'd4);
        check_val("t6_head1", bus.dec_pc_o, exp_pc);
        repeat (3) step();
        #1;
        check_val("t6_err_sticky", 32'(bus.err_o), 32'd1);

        // asynchronous reset mid-stream
        step(); bus.dec_ready_i = 1'b1;
        repeat (4) step();
        mon_en = 0; rst = 1'b1; #1;
        check_val("t6_arst_req", 32'(bus.imem_req_o), 32'd0);
        check_val("t6_arst_addr", bus.imem_addr_o, BASE);
        check_val("t6_arst_valid", 32'(bus.dec_valid_o), 32'd0);
        check_val("t6_arst_count", 32'(bus.count_o), 32'd0);
        check_val("t6_arst_err", 32'(bus.err_o), 32'd0);
        check_val("t6_arst_pc", bus.dec_pc_o, 32'd0);
        repeat (2) step();
        step(); rst = 1'b0; exp_pc = BASE; mon_en = 1; #1;
        check_val("t6_rel_addr", bus.imem_addr_o, BASE);
        step(); step(); #1;
        check_val("t6_rel_valid", 32'(bus.dec_valid_o), 32'd1);
        check_val("t6_rel_pc", bus.dec_pc_o, BASE);
        repeat (4) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
